// File: rtl/debug_word_tx.sv
// Word-to-byte transmit responder: takes one NBITS word from the debug controller and
// feeds it LSB byte first to a UART byte transmitter, then holds off for a guard gap.
module debug_word_tx #(
  parameter int NBITS      = 32,
  parameter int BYTE_W     = 8,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [NBITS-1:0]  tx_Data,
  input  logic              byte_tx_done,
  output logic [BYTE_W-1:0] byte_tx_data,
  output logic              byte_tx_start,
  output logic              tx_done,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int NB    = NBITS / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  if ((NBITS % BYTE_W) != 0 || NB < 1) begin : g_bad_width
    $error("debug_word_tx: NBITS must be a non-zero multiple of BYTE_W");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("debug_word_tx: GAP_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             state, state_nxt;
  logic [NBITS-1:0]   shreg, shreg_nxt, shreg_shift;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [BYTE_W-1:0]  data_nxt;
  logic               start_nxt;
  logic               done_nxt;
  logic               busy_nxt;
  logic [CNT_W-1:0]   wc_nxt;

  // The byte in flight always sits in the low bits; the next one is one shift away.
  assign shreg_shift = shreg >> BYTE_W;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    gap_nxt   = gap_cnt;
    data_nxt  = byte_tx_data;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    wc_nxt    = word_count;

    unique case (state)
      S_IDLE: begin
        if (tx_start) begin
          shreg_nxt = tx_Data;
          data_nxt  = tx_Data[BYTE_W-1:0];
          start_nxt = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        // A done that coincides with our own start pulse still completes that byte.
        if (byte_tx_done) begin
          if (idx == IDX_LAST) begin
            done_nxt  = 1'b1;
            wc_nxt    = word_count + 1'b1;
            gap_nxt   = GAP_LOAD;
            state_nxt = S_GAP;
          end else begin
            idx_nxt   = idx + 1'b1;
            shreg_nxt = shreg_shift;
            data_nxt  = shreg_shift[BYTE_W-1:0];
            start_nxt = 1'b1;
          end
        end
      end

      S_GAP: begin
        // Gives the controller time to update its registered word before we resample.
        if (gap_cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      shreg         <= '0;
      idx           <= '0;
      gap_cnt       <= '0;
      byte_tx_data  <= '0;
      byte_tx_start <= 1'b0;
      tx_done       <= 1'b0;
      busy          <= 1'b0;
      word_count    <= '0;
    end else begin
      state         <= state_nxt;
      shreg         <= shreg_nxt;
      idx           <= idx_nxt;
      gap_cnt       <= gap_nxt;
      byte_tx_data  <= data_nxt;
      byte_tx_start <= start_nxt;
      tx_done       <= done_nxt;
      busy          <= busy_nxt;
      word_count    <= wc_nxt;
    end
  end

  a_done_in_gap : assert property (@(posedge clk) disable iff (reset)
    tx_done |-> (state == S_GAP));
  a_start_in_wait : assert property (@(posedge clk) disable iff (reset)
    byte_tx_start |-> (state == S_WAIT));
  a_busy_matches : assert property (@(posedge clk) disable iff (reset)
    busy == (state != S_IDLE));

endmodule

// File: tb/tb_debug_word_tx.sv
// Scoreboard bench for debug_word_tx: a UART byte model answers each start, and a
// monitor pops expected bytes and word counts as the DUT emits them.
module tb_debug_word_tx;

  localparam int NBITS      = 32;
  localparam int BYTE_W     = 8;
  localparam int GAP_CYCLES = 2;
  localparam int CNT_W      = 16;
  localparam int BUDGET     = 500;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              tx_start = 1'b0;
  logic [NBITS-1:0]  tx_Data = '0;
  logic              byte_tx_done = 1'b0;
  logic [BYTE_W-1:0] byte_tx_data;
  logic              byte_tx_start;
  logic              tx_done;
  logic              busy;
  logic [CNT_W-1:0]  word_count;

  always #5 clk = ~clk;

  debug_word_tx #(
    .NBITS(NBITS), .BYTE_W(BYTE_W), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .tx_Data      (tx_Data),
    .byte_tx_done (byte_tx_done),
    .byte_tx_data (byte_tx_data),
    .byte_tx_start(byte_tx_start),
    .tx_done      (tx_done),
    .busy         (busy),
    .word_count   (word_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [BYTE_W-1:0] exp_bytes[$];
  logic [CNT_W-1:0]  exp_wc[$];
  logic [CNT_W-1:0]  exp_wc_val = '0;

  int n_starts = 0, n_txdone = 0, extra_starts = 0, extra_txdone = 0, gap_left = 0;
  int uart_lat = 10, uart_cnt = 0, n_bdone = 0, inj_req = 0, inj_ack = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART byte transmitter model: done after uart_lat cycles (same cycle when 0),
  // plus stray pulses requested by the stimulus.
  always @(negedge clk) begin
    byte_tx_done = 1'b0;
    if (reset) begin
      uart_cnt = 0;
    end else begin
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) byte_tx_done = 1'b1;
      end
      if (byte_tx_start) begin
        if (uart_lat == 0) byte_tx_done = 1'b1;
        else uart_cnt = uart_lat;
      end
      if (inj_req != inj_ack) begin
        byte_tx_done = 1'b1;
        inj_ack++;
      end
      if (byte_tx_done) n_bdone++;
    end
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (gap_left > 0) begin
        check("start_in_gap", {31'd0, byte_tx_start}, 32'd0);
        gap_left--;
      end
      if (byte_tx_start) begin
        n_starts++;
        if (exp_bytes.size() == 0) extra_starts++;
        else check("byte_data", {24'd0, byte_tx_data}, {24'd0, exp_bytes.pop_front()});
      end
      if (tx_done) begin
        n_txdone++;
        gap_left = GAP_CYCLES;
        if (exp_wc.size() == 0) extra_txdone++;
        else check("word_count_at_done", {16'd0, word_count}, {16'd0, exp_wc.pop_front()});
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(w[8*i +: 8]);
    exp_wc_val = exp_wc_val + 1'b1;
    exp_wc.push_back(exp_wc_val);
  endtask

  task automatic send_word(input logic [31:0] w);
    push_word(w);
    tx_Data  = w;
    tx_start = 1'b1;
    @(negedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_txdone(input int target, input string tag);
    int k = 0;
    while (n_txdone < target && k < BUDGET) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, n_txdone, target);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int k = 0;
    while (n_starts < target && k < BUDGET) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, n_starts, target);
  endtask

  task automatic wait_bdone(input int target, input string tag);
    int k = 0;
    while (n_bdone < target && k < BUDGET) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, n_bdone, target);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < BUDGET) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, d0, b0, k;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, byte_tx_start}, 32'd0);
    check("rst_txdone", {31'd0, tx_done}, 32'd0);
    check("rst_data", {24'd0, byte_tx_data}, 32'd0);
    check("rst_wc", {16'd0, word_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;

    // 1: single word, 10-cycle UART
    s0 = n_starts;
    send_word(32'h1122_3344);
    wait_txdone(1, "t1_txdone");
    check("t1_busy_at_done", {31'd0, busy}, 32'd1);
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check("t1_busy_low_delay", k, GAP_CYCLES + 1);
    check("t1_starts", n_starts - s0, 4);
    check("t1_wc", {16'd0, word_count}, 32'd1);

    // 2: tx_start held across two words, data changed in first GAP cycle
    s0 = n_starts;
    push_word(32'hAABB_CCDD);
    push_word(32'h0102_0304);
    tx_Data  = 32'hAABB_CCDD;
    tx_start = 1'b1;
    wait_txdone(2, "t2_first_done");
    tx_Data = 32'h0102_0304;
    wait_starts(s0 + 5, "t2_second_accept");
    tx_start = 1'b0;
    wait_txdone(3, "t2_second_done");
    wait_idle("t2_idle");
    check("t2_starts", n_starts - s0, 8);
    check("t2_wc", {16'd0, word_count}, 32'd3);

    // 3: tx_Data changes while the word is in flight
    s0 = n_starts;
    send_word(32'h1234_5678);
    wait_starts(s0 + 2, "t3_second_byte");
    tx_Data = 32'hFFFF_FFFF;
    wait_txdone(4, "t3_done");
    wait_idle("t3_idle");
    check("t3_starts", n_starts - s0, 4);

    // 4: reset after the second byte completes
    s0 = n_starts;
    d0 = n_txdone;
    b0 = n_bdone;
    send_word(32'hCAFE_F00D);
    wait_bdone(b0 + 2, "t4_two_bytes");
    reset = 1'b1;
    #1;
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_start", {31'd0, byte_tx_start}, 32'd0);
    check("t4_rst_txdone", {31'd0, tx_done}, 32'd0);
    check("t4_rst_data", {24'd0, byte_tx_data}, 32'd0);
    check("t4_rst_wc", {16'd0, word_count}, 32'd0);
    exp_bytes.delete();
    exp_wc.delete();
    exp_wc_val = '0;
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check("t4_no_txdone", n_txdone - d0, 0);
    check("t4_partial_starts", n_starts - s0, 2);
    s0 = n_starts;
    send_word(32'h5A5A_A5A5);
    wait_txdone(d0 + 1, "t4_new_done");
    wait_idle("t4_idle");
    check("t4_new_starts", n_starts - s0, 4);
    check("t4_wc", {16'd0, word_count}, 32'd1);

    // 5: stray byte_tx_done in IDLE and in GAP
    s0 = n_starts;
    d0 = n_txdone;
    inj_req++;
    repeat (4) @(negedge clk);
    #1;
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    check("t5_idle_txdone", n_txdone - d0, 0);
    check("t5_idle_wc", {16'd0, word_count}, 32'd1);
    send_word(32'h0BAD_BEEF);
    wait_txdone(d0 + 1, "t5_done");
    inj_req++;
    wait_idle("t5_idle");
    repeat (4) @(negedge clk);
    #1;
    check("t5_gap_txdone", n_txdone - d0, 1);
    check("t5_gap_wc", {16'd0, word_count}, 32'd2);
    check("t5_starts", n_starts - s0, 4);

    // 6: counter wrap with a zero-latency UART
    uart_lat = 0;
    s0 = n_starts;
    d0 = n_txdone;
    force dut.word_count = 16'hFFFF;
    repeat (2) @(negedge clk);
    #1;
    release dut.word_count;
    #1;
    check("t6_preload", {16'd0, word_count}, 32'h0000_FFFF);
    exp_wc_val = 16'hFFFF;
    send_word(32'h89AB_CDEF);
    wait_txdone(d0 + 1, "t6_done");
    wait_idle("t6_idle");
    check("t6_wc_wrap", {16'd0, word_count}, 32'd0);
    check("t6_starts", n_starts - s0, 4);

    repeat (5) @(negedge clk);
    #1;
    check("extra_starts", extra_starts, 0);
    check("extra_txdone", extra_txdone, 0);
    check("bytes_drained", exp_bytes.size(), 0);
    check("wc_drained", exp_wc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debug_word_tx.md
Name: debug_word_tx

Overview:
- Transmit-side responder for the debug controller's 32-bit word interface (tx_start / tx_Data / tx_done).
- Accepts a word, splits it into 4 bytes (LSB first), and feeds them one at a time to the UART byte transmitter using a pulse start / pulse done handshake.
- Returns a single-cycle tx_done per word, then applies a guard gap so the controller's registered data can update before the next word is sampled.
- Sits between the debug controller and the UART byte transmitter.

Parameters:
- NBITS, 32, word width; must be a multiple of 8.
- BYTE_W, 8, UART byte width.
- GAP_CYCLES, 2, number of cycles after tx_done during which tx_start is ignored; minimum 1.
- CNT_W, 16, width of word_count.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- tx_start  input  1  level request from the controller; may stay high across many words.
- tx_Data  input  NBITS  word to send; sampled only on acceptance.
- byte_tx_done  input  1  one-cycle pulse from the UART TX when the current byte has fully gone out (stop bit finished).
- byte_tx_data  output  BYTE_W  byte presented to the UART TX; stable from byte_tx_start until byte_tx_done.
- byte_tx_start  output  1  one-cycle pulse that launches a byte.
- tx_done  output  1  one-cycle pulse when all 4 bytes of a word are sent.
- busy  output  1  high in every state except IDLE.
- word_count  output  CNT_W  number of words completed since reset; wraps.

Behaviour:
- Clock domain and reset: reset is asynchronous, active-high; clock is clk. All outputs are registered.
- Reset values: byte_tx_data=0, byte_tx_start=0, tx_done=0, busy=0, word_count=0, state=IDLE, byte index=0, gap counter=0.
- Reset mid-word: abort immediately; no tx_done is issued and the partial word is discarded.
- NB = NBITS/BYTE_W (4 by default).

States:
- IDLE:
  - If tx_start=1 at a clock edge: shift register <= tx_Data; byte_tx_data <= tx_Data[7:0]; byte_tx_start <= 1; idx <= 0; go to WAIT.
  - Latency: first byte_tx_start is high in the cycle after tx_start is sampled high.
  - byte_tx_done while in IDLE is ignored.
- WAIT:
  - byte_tx_start is high only in the first WAIT cycle, then 0.
  - On byte_tx_done with idx<NB-1: idx+1; byte_tx_data <= next byte (bits [8*(idx+1)+7 : 8*(idx+1)]); byte_tx_start <= 1 in the next cycle. The gap from done to the next start is exactly 1 cycle.
  - On byte_tx_done with idx==NB-1: tx_done <= 1 for one cycle; word_count <= word_count+1 (modulo 2^CNT_W); gap counter <= GAP_CYCLES; go to GAP.
  - byte_tx_done in the same cycle as byte_tx_start is high counts as completion of that byte.
- GAP:
  - tx_done is high during the first GAP cycle only.
  - Counter decrements each cycle; tx_start and tx_Data are ignored.
  - When the counter reaches 0, go to IDLE. A tx_start still high then restarts immediately with the tx_Data present at that edge.

Other rules:
- tx_Data changes after acceptance have no effect on the word in flight.
- tx_start dropping mid-word does not abort the word.
- Exactly one tx_done per accepted word, and never more than NB byte_tx_start pulses per word.
- byte_tx_done pulses beyond those expected in WAIT have no effect outside WAIT.

Test Plan:
1. UART model answers byte_tx_done 10 cycles after each start; tx_start=1 for 1 cycle with tx_Data=0x11223344 -> byte_tx_data sequence 0x44, 0x33, 0x22, 0x11; 4 byte_tx_start pulses each 1 cycle wide; one tx_done; word_count=1; busy low again GAP_CYCLES+1 cycles after tx_done.
2. tx_start held high; tx_Data=0xAABBCCDD, changed to 0x01020304 in the first GAP cycle -> first word sent as DD, CC, BB, AA; second word sent as 04, 03, 02, 01; two tx_done pulses; no byte_tx_start while in GAP.
3. Change tx_Data to 0xFFFFFFFF during the second byte of word 0x12345678 -> bytes sent are 78, 56, 34, 12.
4. Assert reset for 1 cycle after the 2nd byte_tx_done -> all outputs return to reset values that cycle; no tx_done; word_count=0; a new tx_start sends a full 4 bytes.
5. Pulse byte_tx_done while in IDLE, plus an extra pulse during GAP -> no state change, no tx_done, word_count unchanged.
6. Preload 65535 words (force word_count=0xFFFF), then send one word -> word_count wraps to 0x0000; UART model responding with byte_tx_done in the same cycle as the start still yields exactly 4 bytes.
